// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM state encoding (also shown on
// the stage LEDs) and the result selection.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    READY   = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } calc_state_t;

  typedef enum logic {
    SEL_QUOT = 1'b0,
    SEL_REM  = 1'b1
  } sel_t;

endpackage

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Loads on start while idle, runs WIDTH iterations, then pulses done for one cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_27mhz,
  input  logic             reset,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    // Partial remainder shifted left with the next dividend bit: WIDTH+1 bits.
    shifted = {rem_q, quo_q[WIDTH-1]};
    if (abort) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      quo_d  = '0;
      rem_d  = '0;
      dvs_d  = '0;
    end else if (busy_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_27mhz or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand-entry sequencer around seq_divider: captures dividend and divisor,
// launches the division, and holds/presents quotient or remainder with status.
module calc_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_27mhz,
  input  logic             reset,
  input  logic             op_div,
  input  logic             op_quot,
  input  logic             op_rem,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] num_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic [2:0]       stage
);

  import calc_pkg::*;

  calc_state_t      state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_hold_q, quot_hold_d;
  logic [WIDTH-1:0] rem_hold_q, rem_hold_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk_27mhz (clk_27mhz),
    .reset     (reset),
    .abort     (op_clear),
    .start     (start_q),
    .dividend  (dividend_q),
    .divisor   (divisor_q),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quot_hold_d = quot_hold_q;
    rem_hold_d  = rem_hold_q;
    start_d     = 1'b0;
    if (op_clear) begin
      state_d     = ENTER_A;
      sel_d       = SEL_QUOT;
      dividend_d  = '0;
      divisor_d   = '0;
      quot_hold_d = '0;
      rem_hold_d  = '0;
    end else begin
      unique case (state_q)
        ENTER_A: if (op_div) begin
          dividend_d = num_in;
          state_d    = ENTER_B;
        end
        ENTER_B: if (op_div) begin
          divisor_d = num_in;
          state_d   = READY;
        end
        READY: if (op_quot || op_rem) begin
          sel_d = op_quot ? SEL_QUOT : SEL_REM;
          if (divisor_q == '0) begin
            state_d = ERR;
          end else begin
            start_d = 1'b1;
            state_d = CALC;
          end
        end
        CALC: if (div_done) begin
          quot_hold_d = div_quot;
          rem_hold_d  = div_rem;
          state_d     = SHOW;
        end
        SHOW: begin
          if (op_quot) sel_d = SEL_QUOT;
          else if (op_rem) sel_d = SEL_REM;
        end
        ERR: ;
        default: state_d = ENTER_A;
      endcase
    end

    // Outputs are registered from next-state values so they line up with stage.
    // busy waits for the divider to actually load (start_q) before rising.
    valid_d = (state_d == SHOW);
    dbz_d   = (state_d == ERR);
    busy_d  = (state_d == CALC) && (start_q || div_busy);
    if (state_d == SHOW) result_d = (sel_d == SEL_QUOT) ? quot_hold_d : rem_hold_d;
    else if (state_d == ERR) result_d = '1;
    else result_d = '0;
  end

  always_ff @(posedge clk_27mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ENTER_A;
      sel_q       <= SEL_QUOT;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_hold_q <= '0;
      rem_hold_q  <= '0;
      start_q     <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quot_hold_q <= quot_hold_d;
      rem_hold_q  <= rem_hold_d;
      start_q     <= start_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign div_by_zero  = dbz_q;
  assign stage        = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer (WIDTH=8): directed vector table,
// multi-cycle corner sequences, and randomized division against plain arithmetic.
module tb_calc_sequencer;

  localparam int W = 8;

  logic         clk_27mhz = 1'b0;
  logic         reset;
  logic         op_div, op_quot, op_rem, op_clear;
  logic [W-1:0] num_in;
  logic [W-1:0] result;
  logic         result_valid, busy, div_by_zero;
  logic [2:0]   stage;

  int checks = 0;
  int failures = 0;

  calc_sequencer #(.WIDTH(W)) dut (
    .clk_27mhz    (clk_27mhz),
    .reset        (reset),
    .op_div       (op_div),
    .op_quot      (op_quot),
    .op_rem       (op_rem),
    .op_clear     (op_clear),
    .num_in       (num_in),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .div_by_zero  (div_by_zero),
    .stage        (stage)
  );

  always #5 clk_27mhz = ~clk_27mhz;

  typedef struct {
    int a;
    int b;
    bit use_rem;
    int exp_result;
    bit exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives the given pulses across exactly one rising edge; returns at the next negedge.
  task automatic pulse(input bit d, input bit q, input bit r, input bit c);
    op_div = d; op_quot = q; op_rem = r; op_clear = c;
    @(negedge clk_27mhz);
    op_div = 0; op_quot = 0; op_rem = 0; op_clear = 0;
  endtask

  task automatic enter(input int a, input int b);
    num_in = W'(a);
    pulse(1, 0, 0, 0);
    num_in = W'(b);
    pulse(1, 0, 0, 0);
    num_in = W'($urandom);
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (!result_valid && !div_by_zero && n < 30) begin
      @(negedge clk_27mhz);
      n++;
    end
    if (n >= 30) check({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    int busy_cycles, first_valid, q, r, dq, dr, a, b;
    op_div = 0; op_quot = 0; op_rem = 0; op_clear = 0; num_in = '0;
    reset = 1;
    #12;
    check("rst_result", int'(result), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    check("rst_stage", int'(stage), 0);
    @(negedge clk_27mhz);
    reset = 0;
    @(negedge clk_27mhz);

    // Directed vector table.
    vecs[0]  = '{100, 7, 0, 14, 0};
    vecs[1]  = '{100, 7, 1, 2, 0};
    vecs[2]  = '{5, 9, 1, 5, 0};
    vecs[3]  = '{5, 9, 0, 0, 0};
    vecs[4]  = '{255, 1, 0, 255, 0};
    vecs[5]  = '{255, 255, 0, 1, 0};
    vecs[6]  = '{255, 255, 1, 0, 0};
    vecs[7]  = '{9, 2, 0, 4, 0};
    vecs[8]  = '{9, 2, 1, 1, 0};
    vecs[9]  = '{0, 5, 0, 0, 0};
    vecs[10] = '{200, 3, 1, 2, 0};
    vecs[11] = '{7, 0, 0, 255, 1};
    for (int i = 0; i < 12; i++) begin
      pulse(0, 0, 0, 1);
      enter(vecs[i].a, vecs[i].b);
      pulse(0, !vecs[i].use_rem, vecs[i].use_rem, 0);
      wait_result("vec");
      check($sformatf("vec%0d_result", i), int'(result), vecs[i].exp_result);
      check($sformatf("vec%0d_valid", i), int'(result_valid), vecs[i].exp_err ? 0 : 1);
      check($sformatf("vec%0d_dbz", i), int'(div_by_zero), int'(vecs[i].exp_err));
    end

    // Latency: busy WIDTH+1 cycles, result_valid at edge k+WIDTH+2.
    pulse(0, 0, 0, 1);
    enter(100, 7);
    pulse(0, 1, 0, 0);
    check("lat_busy_k", int'(busy), 0);
    busy_cycles = 0; first_valid = -1;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge clk_27mhz);
      if (busy) busy_cycles++;
      if (result_valid && first_valid < 0) begin
        first_valid = n;
        check("lat_busy_at_valid", int'(busy), 0);
      end
    end
    check("lat_busy_cycles", busy_cycles, W + 1);
    check("lat_valid_cycle", first_valid, W + 2);
    check("lat_quot", int'(result), 14);
    pulse(0, 0, 1, 0);
    check("resel_rem", int'(result), 2);
    check("resel_busy", int'(busy), 0);
    pulse(1, 0, 0, 0);
    check("show_div_ignored_stage", int'(stage), 4);
    check("show_div_ignored_busy", int'(busy), 0);
    pulse(0, 1, 0, 0);
    check("resel_quot", int'(result), 14);

    // Divide by zero.
    pulse(0, 0, 0, 1);
    enter(42, 0);
    pulse(0, 1, 0, 0);
    check("err_stage", int'(stage), 5);
    check("err_dbz", int'(div_by_zero), 1);
    check("err_result", int'(result), 255);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    check("err_hold_stage", int'(stage), 5);
    check("err_hold_result", int'(result), 255);
    pulse(0, 0, 0, 1);
    check("err_clr_stage", int'(stage), 0);
    check("err_clr_result", int'(result), 0);
    check("err_clr_dbz", int'(div_by_zero), 0);
    check("err_clr_valid", int'(result_valid), 0);

    // Clear mid-calculation, stale done must not show.
    enter(200, 3);
    pulse(0, 1, 0, 0);
    repeat (3) @(negedge clk_27mhz);
    pulse(0, 0, 0, 1);
    check("abort_stage", int'(stage), 0);
    check("abort_busy", int'(busy), 0);
    first_valid = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk_27mhz);
      if (result_valid || stage != 3'd0) first_valid = 1;
    end
    check("abort_no_valid", first_valid, 0);
    enter(9, 2);
    pulse(0, 1, 0, 0);
    wait_result("fresh");
    check("fresh_quot", int'(result), 4);
    pulse(0, 0, 1, 0);
    check("fresh_rem", int'(result), 1);

    // Simultaneous pulses.
    pulse(0, 0, 0, 1);
    enter(100, 7);
    pulse(0, 1, 1, 0);
    wait_result("both");
    check("both_quot_wins", int'(result), 14);
    pulse(0, 0, 0, 1);
    num_in = 8'd77;
    pulse(1, 0, 0, 1);
    check("clr_div_stage", int'(stage), 0);
    enter(50, 5);
    pulse(0, 1, 0, 0);
    wait_result("clr_div");
    check("clr_div_result", int'(result), 10);

    // Asynchronous reset between edges while calculating.
    pulse(0, 0, 0, 1);
    enter(100, 7);
    pulse(0, 1, 0, 0);
    repeat (2) @(negedge clk_27mhz);
    #2 reset = 1;
    #1;
    check("areset_busy", int'(busy), 0);
    check("areset_stage", int'(stage), 0);
    check("areset_result", int'(result), 0);
    check("areset_valid", int'(result_valid), 0);
    @(negedge clk_27mhz);
    reset = 0;
    @(negedge clk_27mhz);

    // Randomized divisions against plain arithmetic.
    for (int i = 0; i < 500; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      q = a / b;
      r = a % b;
      pulse(0, 0, 0, 1);
      enter(a, b);
      pulse(0, 1, 0, 0);
      wait_result("rnd");
      dq = int'(result);
      check("rnd_quot", dq, q);
      pulse(0, 0, 1, 0);
      dr = int'(result);
      check("rnd_rem", dr, r);
      check("rnd_invariant", dq * b + dr, a);
      check("rnd_rem_lt_div", int'(dr < b), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
